// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared constants, FSM states and width helper for product_accumulator (ACC_SAT_EN-aware users)
package product_acc_pkg;
  localparam int PROD_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/product_accumulator_acc_adder.sv
// acc_adder: unsigned W-bit adder, wrapping by default, clamping with ovf when ACC_SAT_EN is defined
module acc_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
`ifdef ACC_SAT_EN
  , output logic ovf
`endif
);
`ifdef ACC_SAT_EN
  logic [W:0] full;
  assign full = {1'b0, a} + {1'b0, b};
  assign ovf = full[W];
  assign sum = ovf ? '1 : full[W-1:0];
`else
  assign sum = a + b;
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums BLOCK_LEN products per block and offers the total on a valid/ready channel; ACC_SAT_EN adds clamping and acc_ovf
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int BLOCK_LEN = 16,
  parameter int ACC_W     = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PROD_W-1:0]            product,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic [ACC_W-1:0]             acc_data,
  output logic [cnt_w(BLOCK_LEN)-1:0]  beat_cnt
`ifdef ACC_SAT_EN
  , output logic                       acc_ovf
`endif
);
  localparam int CW = cnt_w(BLOCK_LEN);
  state_t state, state_n;
  logic [ACC_W-1:0] acc, sum;
  logic [CW-1:0] cnt_nx;
  logic active, accept, last, xfer;
`ifdef ACC_SAT_EN
  logic ovf;
`endif
  assign in_ready = state != HOLD && !clear;
  assign active = state == IDLE || state == ACCUM;
  assign accept = in_valid && in_ready && active;
  assign xfer = state == HOLD && acc_valid && acc_ready;
  assign cnt_nx = state == ACCUM ? beat_cnt + 1'b1 : CW'(1);
  assign last = cnt_nx == CW'(BLOCK_LEN);
  acc_adder #(.W(ACC_W)) u_add (
    .a   (state == ACCUM ? acc : '0),
    .b   (ACC_W'(product)),
    .sum (sum)
`ifdef ACC_SAT_EN
    , .ovf (ovf)
`endif
  );
  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: clear aborts, last beat enters HOLD, transfer or illegal code returns to IDLE
  always_comb begin
    state_n = IDLE;
    if (!clear) state_n = active ? (accept ? (last ? HOLD : ACCUM) : state) : (state == HOLD && !xfer ? HOLD : IDLE);
  end
  // running sum, beat count and the block total held for the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      beat_cnt <= '0;
      acc_data <= '0;
      acc_valid <= 1'b0;
    end else if (clear || xfer || !(active || state == HOLD)) begin
      acc <= '0;
      beat_cnt <= '0;
      acc_valid <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      beat_cnt <= cnt_nx;
      if (last) begin
        acc_data <= sum;
        acc_valid <= 1'b1;
      end
    end
  end
`ifdef ACC_SAT_EN
  // sticky clamp flag, dropped when the block leaves or is aborted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_ovf <= 1'b0;
    else if (clear || xfer) acc_ovf <= 1'b0;
    else if (accept && ovf) acc_ovf <= 1'b1;
  end
`endif
endmodule
